up_counter8_ctrl: RTL

//   Controlled up counter fed by the clock-aligned reset from the reset synchronizer stage.

---
 rtl/up_counter8_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/up_counter8_ctrl.sv
// rtl/up_counter8_ctrl.sv - controlled up counter with load, start/stop, terminal-count pulse and sticky overflow
// Build option: define COUNTER_SATURATE_EN to hold at MAX_COUNT and halt instead of wrapping.
`timescale 1ns/1ps
module up_counter8_ctrl #(
  parameter int          WIDTH     = 8,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  output logic [WIDTH-1:0] Count,
  output logic             Running,
  output logic             TC,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             ovf_nxt;
  logic [WIDTH-1:0] load_val;

  assign load_val = (Data > MAX_V) ? MAX_V : Data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      Count    <= '0;
      TC       <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      Count    <= count_nxt;
      TC       <= tc_nxt;
      Overflow <= ovf_nxt;
    end
  end

  // Only one action per edge: Load, then Stop, then Start, then counting.
  always_comb begin
    state_nxt = state;
    count_nxt = Count;
    tc_nxt    = 1'b0;
    ovf_nxt   = Overflow;
    if (Load) begin
      count_nxt = load_val;
      ovf_nxt   = 1'b0;
    end else if (Stop) begin
      state_nxt = S_IDLE;
    end else if (Start && (state != S_RUN)) begin
      state_nxt = S_RUN;
    end else if (state == S_RUN) begin
      if (Count == MAX_V) begin
        ovf_nxt = 1'b1;
`ifdef COUNTER_SATURATE_EN
        state_nxt = S_HALT;
`else
        count_nxt = '0;
`endif
      end else begin
        count_nxt = Count + ONE;
        tc_nxt    = (Count == (MAX_V - ONE));
      end
    end
  end

  assign Running = (state == S_RUN);

endmodule
